// File: rtl/ghrd_reset_sequencer.sv
// ghrd_reset_sequencer: releases fabric reset domains in ascending order after init/EMIF cal,
// with per-domain software re-reset. Optional macro GHRD_RSTSEQ_EVCNT_EN adds rst_event_cnt.
module ghrd_reset_sequencer #(
    parameter int NUM_DOMAINS = 4,
    parameter int CNT_W       = 16,
    parameter int STAGE_DELAY = 1000,
    parameter int HOLD_CYCLES = 64,
    parameter int CAL_TIMEOUT = 50000
) (
    input  logic                   clk_100_clk,
    input  logic                   reset_reset,
    input  logic                   ninit_done_ninit_done,
    input  logic                   emif_cal_done,
    input  logic [NUM_DOMAINS-1:0] sw_reset_req,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic [NUM_DOMAINS-1:0] domain_ready,
    output logic [2:0]             seq_state,
`ifdef GHRD_RSTSEQ_EVCNT_EN
    output logic [7:0]             rst_event_cnt,
`endif
    output logic                   timeout_err
);

    localparam logic [2:0] ST_WAIT_INIT = 3'd0;
    localparam logic [2:0] ST_WAIT_CAL  = 3'd1;
    localparam logic [2:0] ST_RELEASE   = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_REARM     = 3'd4;

    localparam int PTR_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0]       STAGE_LOAD = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0]       HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]       CAL_LIMIT  = CNT_W'(CAL_TIMEOUT);
    localparam logic [CNT_W-1:0]       CAL_LAST   = CNT_W'(CAL_TIMEOUT - 1);
    localparam logic [PTR_W-1:0]       PTR_LAST   = PTR_W'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] ALL_HELD   = '1;

    logic [1:0]             r_ninit_sync;
    logic [2:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [PTR_W-1:0]       r_ptr;
    logic [NUM_DOMAINS-1:0] r_domain_reset;
    logic [NUM_DOMAINS-1:0] r_domain_ready;
    logic                   r_timeout_err;

    logic                   w_ninit;
    logic                   w_force_init;
    logic                   w_req_any;
    logic [PTR_W-1:0]       w_req_idx;
    logic [NUM_DOMAINS-1:0] w_req_mask;
    logic                   w_rearm_take;
    logic [2:0]             w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [PTR_W-1:0]       w_ptr_nxt;
    logic [NUM_DOMAINS-1:0] w_rst_nxt;
    logic                   w_timeout_nxt;

    // Lowest set request bit wins; the mask covers that domain and every domain above it.
    always_comb begin
        w_req_any = 1'b0;
        w_req_idx = '0;
        for (int k = NUM_DOMAINS - 1; k >= 0; k--) begin
            if (sw_reset_req[k]) begin
                w_req_any = 1'b1;
                w_req_idx = PTR_W'(k);
            end
        end
        for (int k = 0; k < NUM_DOMAINS; k++) begin
            w_req_mask[k] = (PTR_W'(k) >= w_req_idx);
        end
    end

    assign w_ninit      = r_ninit_sync[1];
    assign w_force_init = w_ninit && (r_state != ST_WAIT_INIT);
    assign w_rearm_take = !w_force_init && w_req_any &&
                          ((r_state == ST_RUN) ||
                           (((r_state == ST_RELEASE) || (r_state == ST_REARM)) && (w_req_idx < r_ptr)));

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ptr_nxt     = r_ptr;
        w_rst_nxt     = r_domain_reset;
        w_timeout_nxt = r_timeout_err;

        if (w_force_init) begin
            w_state_nxt = ST_WAIT_INIT;
            w_cnt_nxt   = '0;
            w_ptr_nxt   = '0;
            w_rst_nxt   = ALL_HELD;
        end else if (w_rearm_take) begin
            w_state_nxt = ST_REARM;
            w_cnt_nxt   = HOLD_LOAD;
            w_ptr_nxt   = w_req_idx;
            w_rst_nxt   = r_domain_reset | w_req_mask;
        end else begin
            case (r_state)
                ST_WAIT_INIT: begin
                    w_rst_nxt = ALL_HELD;
                    w_cnt_nxt = '0;
                    w_ptr_nxt = '0;
                    if (!w_ninit) begin
                        w_state_nxt = ST_WAIT_CAL;
                    end
                end
                ST_WAIT_CAL: begin
                    w_rst_nxt = ALL_HELD;
                    if (emif_cal_done) begin
                        w_state_nxt = ST_RELEASE;
                        w_ptr_nxt   = '0;
                        w_cnt_nxt   = STAGE_LOAD;
                    end else begin
                        // Counter parks at the limit; the flag itself is sticky.
                        if (r_cnt != CAL_LIMIT) begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                        if (r_cnt == CAL_LAST) begin
                            w_timeout_nxt = 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == '0) begin
                        w_rst_nxt[r_ptr] = 1'b0;
                        if (r_ptr == PTR_LAST) begin
                            w_state_nxt = ST_RUN;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_ptr_nxt = r_ptr + PTR_W'(1);
                            w_cnt_nxt = STAGE_LOAD;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    w_cnt_nxt = '0;
                end
                ST_REARM: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_RELEASE;
                        w_cnt_nxt   = STAGE_LOAD;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_WAIT_INIT;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = '0;
                    w_rst_nxt   = ALL_HELD;
                end
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_100_clk) begin
        if (reset_reset) begin
            r_ninit_sync   <= 2'b11;
            r_state        <= ST_WAIT_INIT;
            r_cnt          <= '0;
            r_ptr          <= '0;
            r_domain_reset <= ALL_HELD;
            r_domain_ready <= '0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_ninit_sync   <= {r_ninit_sync[0], ninit_done_ninit_done};
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_ptr          <= w_ptr_nxt;
            r_domain_reset <= w_rst_nxt;
            r_domain_ready <= ~w_rst_nxt;
            r_timeout_err  <= w_timeout_nxt;
        end
    end

`ifdef GHRD_RSTSEQ_EVCNT_EN
    logic [7:0] r_evcnt;

    // Counts every accepted re-reset (including a REARM restart) and every forced return to WAIT_INIT.
    always_ff @(posedge clk_100_clk) begin
        if (reset_reset) begin
            r_evcnt <= 8'd0;
        end else if ((w_rearm_take || w_force_init) && (r_evcnt != 8'hFF)) begin
            r_evcnt <= r_evcnt + 8'd1;
        end
    end

    assign rst_event_cnt = r_evcnt;
`endif

    assign domain_reset = r_domain_reset;
    assign domain_ready = r_domain_ready;
    assign seq_state    = r_state;
    assign timeout_err  = r_timeout_err;

endmodule
